mem_stage_vl: RTL and testbench

MEM_STAGE_VL -- requirements
Module: mem_stage_vl

---
 rtl/mem_stage_vl.sv | 149 ++++++++++++++
 tb/tb_mem_stage_vl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_vl.sv
// Memory-access pipeline stage: holds one instruction, waits for its data-SRAM response,
// and discards responses owed to flushed loads. Optional macro MS_LOAD_FWD_EN lets loads forward once data has returned.
module mem_stage_vl #(
   parameter int PAYLOAD_W  = 138,
   parameter int MAX_CANCEL = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 es_to_ms_valid,
   output logic                 ms_allowin,
   input  logic [PAYLOAD_W-1:0] es_payload,
   input  logic [4:0]           es_ld_op,
   input  logic                 es_req_sent,
   input  logic [31:0]          es_alu_result,
   input  logic                 es_gr_we,
   input  logic [4:0]           es_dest,
   input  logic                 data_sram_data_ok,
   input  logic [31:0]          data_sram_rdata,
   input  logic                 ws_allowin,
   output logic                 ms_to_ws_valid,
   output logic [PAYLOAD_W-1:0] ms_to_ws_payload,
   output logic [31:0]          ms_final_result,
   output logic                 ms_gr_we,
   output logic [4:0]           ms_dest,
   output logic                 ms_fwd_block,
   output logic                 ms_cancel_pending
);

   localparam int CNT_W = (MAX_CANCEL < 1) ? 1 : $clog2(MAX_CANCEL + 1);

   typedef enum logic [1:0] {EMPTY, WAIT, DONE} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cancel_cnt;
   logic [PAYLOAD_W-1:0] payload_p1;
   logic [4:0]           ld_op_p1;
   logic [31:0]          alu_result_p1;
   logic [31:0]          rdata_p1;
   logic                 gr_we_p1;
   logic [4:0]           dest_p1;

   logic accept;
   logic resp_owed;
   logic cancel_inc;
   logic cancel_dec;

   // ld_op is one-hot {ld_w, ld_b, ld_bu, ld_h, ld_hu}
   function automatic logic [31:0] load_extend(input logic [4:0]  op,
                                               input logic [1:0]  addr,
                                               input logic [31:0] data);
      logic signed [7:0]  byte_v;
      logic signed [15:0] half_v;
      logic [31:0]        res;
      case (addr)
         2'b00:   byte_v = data[7:0];
         2'b01:   byte_v = data[15:8];
         2'b10:   byte_v = data[23:16];
         default: byte_v = data[31:24];
      endcase
      half_v = addr[1] ? data[31:16] : data[15:0];
      res    = data;
      if (op[3])      res = {{24{byte_v[7]}}, byte_v};
      else if (op[2]) res = {24'b0, byte_v};
      else if (op[1]) res = {{16{half_v[15]}}, half_v};
      else if (op[0]) res = {16'b0, half_v};
      return res;
   endfunction

   // Saturating up/down counter; simultaneous inc and dec cancel out
   function automatic logic [CNT_W-1:0] cancel_next(input logic [CNT_W-1:0] cnt,
                                                    input logic             inc,
                                                    input logic             dec);
      logic [CNT_W-1:0] res;
      res = cnt;
      if (inc && !dec && (cnt != CNT_W'(MAX_CANCEL)))
         res = cnt + CNT_W'(1);
      else if (dec && !inc && (cnt != '0))
         res = cnt - CNT_W'(1);
      return res;
   endfunction

   assign ms_allowin = (state == EMPTY) || ((state == DONE) && ws_allowin);
   assign accept     = es_to_ms_valid && ms_allowin && !flush;
   assign resp_owed  = (state == WAIT) && data_sram_data_ok && (cancel_cnt == '0);
   assign cancel_dec = data_sram_data_ok && (cancel_cnt != '0);
   // A response arriving with the flush belongs to the killed load, so nothing extra is owed
   assign cancel_inc = flush && (state == WAIT) && !resp_owed;

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (accept) state_nxt = es_req_sent ? WAIT : DONE;
            WAIT:  if (resp_owed) state_nxt = DONE;
            DONE:  if (ws_allowin) state_nxt = accept ? (es_req_sent ? WAIT : DONE) : EMPTY;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= EMPTY;
         cancel_cnt <= '0;
      end else begin
         state      <= state_nxt;
         cancel_cnt <= cancel_next(cancel_cnt, cancel_inc, cancel_dec);
      end
   end

   // ---- stage p1: captured instruction and returned data ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         payload_p1    <= '0;
         ld_op_p1      <= '0;
         alu_result_p1 <= '0;
         gr_we_p1      <= 1'b0;
         dest_p1       <= '0;
         rdata_p1      <= '0;
      end else begin
         if (accept) begin
            payload_p1    <= es_payload;
            ld_op_p1      <= es_ld_op;
            alu_result_p1 <= es_alu_result;
            gr_we_p1      <= es_gr_we;
            dest_p1       <= es_dest;
         end
         if (resp_owed) rdata_p1 <= data_sram_rdata;
      end
   end

   assign ms_to_ws_valid    = (state == DONE) && !flush;
   assign ms_to_ws_payload  = payload_p1;
   assign ms_gr_we          = gr_we_p1;
   assign ms_dest           = dest_p1;
   assign ms_cancel_pending = (cancel_cnt != '0);
   assign ms_final_result   = (ld_op_p1 == 5'b0) ? alu_result_p1
                                                 : load_extend(ld_op_p1, alu_result_p1[1:0], rdata_p1);

`ifdef MS_LOAD_FWD_EN
   assign ms_fwd_block = gr_we_p1 && (state == WAIT);
`else
   assign ms_fwd_block = gr_we_p1 && (state != EMPTY) && (ld_op_p1 != 5'b0);
`endif

endmodule

// File: tb/tb_mem_stage_vl.sv
// Scoreboard bench for mem_stage_vl: directed known-answer scenarios plus randomized traffic
// checked against a transaction-level model of the stage.
module tb_mem_stage_vl;
   localparam int PW   = 138;
   localparam int MAXC = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          es_to_ms_valid;
   logic          ms_allowin;
   logic [PW-1:0] es_payload;
   logic [4:0]    es_ld_op;
   logic          es_req_sent;
   logic [31:0]   es_alu_result;
   logic          es_gr_we;
   logic [4:0]    es_dest;
   logic          data_sram_data_ok;
   logic [31:0]   data_sram_rdata;
   logic          ws_allowin;
   logic          ms_to_ws_valid;
   logic [PW-1:0] ms_to_ws_payload;
   logic [31:0]   ms_final_result;
   logic          ms_gr_we;
   logic [4:0]    ms_dest;
   logic          ms_fwd_block;
   logic          ms_cancel_pending;

   always #5 clk = ~clk;

   mem_stage_vl #(.PAYLOAD_W(PW), .MAX_CANCEL(MAXC)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
      .es_payload(es_payload), .es_ld_op(es_ld_op), .es_req_sent(es_req_sent),
      .es_alu_result(es_alu_result), .es_gr_we(es_gr_we), .es_dest(es_dest),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
      .ms_to_ws_payload(ms_to_ws_payload), .ms_final_result(ms_final_result),
      .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_fwd_block(ms_fwd_block),
      .ms_cancel_pending(ms_cancel_pending)
   );

   typedef struct { logic [4:0] op; logic [31:0] alu; logic gr_we; logic [4:0] dest; logic [PW-1:0] pay; } instr_t;
   typedef struct { logic [31:0] res; logic gr_we; logic [4:0] dest; logic [PW-1:0] pay; } exp_t;
   typedef struct { string name; int sel; logic [31:0] val; } kat_t;

   exp_t   sb[$];
   kat_t   kat_q[$];
   instr_t held;
   bit     m_have, m_ready;
   int     m_dead;
   int     n_tests = 0;
   int     n_fail  = 0;
   logic   exp_valid, exp_fwd;
   kat_t   mk;
   exp_t   me;

   task automatic chk1(string name, logic act, logic want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, want);
      end
   endtask

   task automatic chk32(string name, logic [31:0] act, logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   task automatic chkp(string name, logic [PW-1:0] act, logic [PW-1:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   // Reference load result from byte/halfword lane arithmetic
   function automatic logic [31:0] ref_result(logic [4:0] op, logic [31:0] addr, logic [31:0] rd);
      logic [31:0] v;
      if (op == 5'b0) return addr;
      if (op[4]) return rd;
      if (op[3] || op[2]) begin
         v = (rd >> (8 * int'(addr[1:0]))) & 32'hFF;
         if (op[3] && v >= 32'd128) v = v - 32'd256;
      end else begin
         v = (rd >> (16 * int'(addr[1]))) & 32'hFFFF;
         if (op[1] && v >= 32'h8000) v = v - 32'h10000;
      end
      return v;
   endfunction

   function automatic exp_t make_exp(instr_t h, logic [31:0] rd);
      exp_t e;
      e.res   = ref_result(h.op, h.alu, rd);
      e.gr_we = h.gr_we;
      e.dest  = h.dest;
      e.pay   = h.pay;
      return e;
   endfunction

   function automatic logic [PW-1:0] rand_payload();
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[PW-1:0];
   endfunction

   task automatic model_clear();
      m_have  = 1'b0;
      m_ready = 1'b0;
      m_dead  = 0;
      sb.delete();
   endtask

   // Transaction-level view of one clock edge
   task automatic model_edge();
      bit acc, owed, inc, dec;
      int d;
      acc  = es_to_ms_valid && (!m_have || (m_ready && ws_allowin)) && !flush;
      owed = m_have && !m_ready && data_sram_data_ok && (m_dead == 0);
      dec  = data_sram_data_ok && (m_dead > 0);
      inc  = flush && m_have && !m_ready && !owed;
      d    = m_dead + int'(inc) - int'(dec);
      m_dead = (d > MAXC) ? MAXC : d;
      if (flush) begin
         m_have = 1'b0;
         sb.delete();
      end else begin
         if (m_have && m_ready && ws_allowin) m_have = 1'b0;
         if (owed) begin
            m_ready = 1'b1;
            sb.push_back(make_exp(held, data_sram_rdata));
         end
         if (acc) begin
            held    = '{op: es_ld_op, alu: es_alu_result, gr_we: es_gr_we, dest: es_dest, pay: es_payload};
            m_have  = 1'b1;
            m_ready = !es_req_sent;
            if (!es_req_sent) sb.push_back(make_exp(held, 32'h0));
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset) model_edge();
      #1;
   endtask

   task automatic idle();
      es_to_ms_valid    = 1'b0;
      flush             = 1'b0;
      data_sram_data_ok = 1'b0;
      ws_allowin        = 1'b1;
      es_ld_op          = 5'b0;
      es_req_sent       = 1'b0;
   endtask

   task automatic set_instr(logic [4:0] op, logic [31:0] addr, logic req);
      es_to_ms_valid = 1'b1;
      es_ld_op       = op;
      es_alu_result  = addr;
      es_req_sent    = req;
      es_gr_we       = 1'b1;
      es_dest        = 5'($urandom);
      es_payload     = rand_payload();
   endtask

   task automatic kat(string name, int sel, logic [31:0] val);
      kat_q.push_back('{name: name, sel: sel, val: val});
   endtask

   task automatic load_kat(string name, logic [4:0] op, logic [31:0] addr, logic [31:0] rd,
                           int delay, logic [31:0] want);
      idle(); set_instr(op, addr, 1'b1); cycle(); idle();
      repeat (delay) cycle();
      kat({name, "_early_valid"}, 1, 0);
      data_sram_data_ok = 1'b1; data_sram_rdata = rd; cycle(); idle();
      kat({name, "_result"}, 0, want);
      kat({name, "_valid"}, 1, 1);
      cycle();
   endtask

   // Monitor: compares every DUT presentation against the model and scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         chk1("rst_valid", ms_to_ws_valid, 1'b0);
         chk1("rst_allowin", ms_allowin, 1'b1);
         chk1("rst_pending", ms_cancel_pending, 1'b0);
         chk1("rst_fwd", ms_fwd_block, 1'b0);
         chk32("rst_result", ms_final_result, 32'h0);
         chk1("rst_gr_we", ms_gr_we, 1'b0);
         chk32("rst_dest", {27'b0, ms_dest}, 32'h0);
         chkp("rst_payload", ms_to_ws_payload, '0);
      end else begin
         exp_valid = m_have && m_ready && !flush;
`ifdef MS_LOAD_FWD_EN
         exp_fwd = m_have && held.gr_we && !m_ready;
`else
         exp_fwd = m_have && held.gr_we && (held.op != 5'b0);
`endif
         chk1("valid", ms_to_ws_valid, exp_valid);
         chk1("allowin", ms_allowin, !m_have || (m_ready && ws_allowin));
         chk1("cancel_pending", ms_cancel_pending, m_dead != 0);
         chk1("fwd_block", ms_fwd_block, exp_fwd);
         if (ms_to_ws_valid) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_empty: DUT presented result %h, none expected", ms_final_result);
            end else begin
               me = sb[0];
               chk32("result", ms_final_result, me.res);
               chk1("gr_we", ms_gr_we, me.gr_we);
               chk32("dest", {27'b0, ms_dest}, {27'b0, me.dest});
               chkp("payload", ms_to_ws_payload, me.pay);
               if (ws_allowin) void'(sb.pop_front());
            end
         end
      end
      while (kat_q.size() > 0) begin
         mk = kat_q.pop_front();
         case (mk.sel)
            0:       chk32(mk.name, ms_final_result, mk.val);
            1:       chk1(mk.name, ms_to_ws_valid, mk.val[0]);
            2:       chk1(mk.name, ms_cancel_pending, mk.val[0]);
            default: chk1(mk.name, ms_allowin, mk.val[0]);
         endcase
      end
   end

   initial begin
      reset = 1'b0;
      es_payload = '0; es_alu_result = '0; es_gr_we = 1'b0; es_dest = '0; data_sram_rdata = '0;
      idle();
      model_clear();
      repeat (3) cycle();
      reset = 1'b1;
      cycle();

      // ld_b 0x1003, response two cycles after accept
      load_kat("ld_b_1003", 5'b01000, 32'h1003, 32'h80FF_0000, 1, 32'hFFFF_FF80);
      load_kat("ld_hu_2002", 5'b00001, 32'h2002, 32'hBEEF_1234, 0, 32'h0000_BEEF);
      load_kat("ld_h_2002", 5'b00010, 32'h2002, 32'hBEEF_1234, 0, 32'hFFFF_BEEF);
      load_kat("ld_bu_1001", 5'b00100, 32'h1001, 32'h0000_9A00, 2, 32'h0000_009A);
      load_kat("ld_w", 5'b10000, 32'h3000, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);

      // Flush in WAIT, new load, stale response then the real one
      idle(); set_instr(5'b10000, 32'h100, 1'b1); cycle(); idle();
      flush = 1'b1; cycle(); idle();
      kat("flush_pending", 2, 1);
      set_instr(5'b10000, 32'h104, 1'b1); cycle(); idle();
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11; cycle(); idle();
      kat("stale_discard_valid", 1, 0);
      kat("stale_pending_clear", 2, 0);
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h22; cycle(); idle();
      kat("owed_result", 0, 32'h22);
      kat("owed_valid", 1, 1);
      cycle();

      // Flush and data_ok together in WAIT
      set_instr(5'b10000, 32'h200, 1'b1); cycle(); idle();
      flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h33; cycle(); idle();
      kat("flush_ok_pending", 2, 0);
      kat("flush_ok_allowin", 3, 1);
      kat("flush_ok_valid", 1, 0);
      cycle();

      // Four flushed loads saturate the cancel count at 3, then three responses drain it
      for (int i = 0; i < 4; i++) begin
         set_instr(5'b10000, 32'h400 + 32'(i * 4), 1'b1); cycle(); idle();
         flush = 1'b1; cycle(); idle();
         kat("sat_pending", 2, 1);
      end
      for (int i = 0; i < 3; i++) begin
         data_sram_data_ok = 1'b1; data_sram_rdata = $urandom; cycle(); idle();
         kat("drain_pending", 2, (i < 2) ? 32'd1 : 32'd0);
      end
      cycle();

      // Reset mid-WAIT, then a response after release is ignored
      set_instr(5'b01000, 32'h503, 1'b1); cycle(); idle();
      reset = 1'b0;
      model_clear();
      kat("midwait_rst_allowin", 3, 1);
      cycle(); cycle();
      reset = 1'b1;
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; cycle(); idle();
      kat("post_rst_valid", 1, 0);
      kat("post_rst_allowin", 3, 1);
      cycle();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int k;
         idle();
         k = $urandom_range(0, 5);
         es_to_ms_valid    = ($urandom_range(0, 1) == 1);
         es_ld_op          = (k == 5) ? 5'b0 : 5'(1 << k);
         es_alu_result     = $urandom;
         if (es_ld_op[1] || es_ld_op[0]) es_alu_result[0] = 1'b0;
         es_req_sent       = (es_ld_op != 5'b0) ? 1'b1 : ($urandom_range(0, 1) == 1);
         es_gr_we          = ($urandom_range(0, 1) == 1);
         es_dest           = 5'($urandom);
         es_payload        = rand_payload();
         data_sram_data_ok = ($urandom_range(0, 9) < 4);
         data_sram_rdata   = $urandom;
         ws_allowin        = ($urandom_range(0, 9) < 7);
         flush             = ($urandom_range(0, 11) == 0);
         cycle();
      end
      idle();
      repeat (2) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
